// File: rtl/pio_leds_arbiter_pkg.sv
// Shared types and constants for the LED PIO write arbiter.
package pio_leds_arb_pkg;

  // Arbiter sequence: IDLE -> WRITE -> [READ] -> ACK -> IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  // The LED image lives in the PIO data register
  localparam logic [1:0] PIO_LEDS_DATA_ADDR = 2'd0;

  // Width of the Avalon-MM data bus on the PIO slave
  localparam int PIO_DATA_W_MAX = 32;

endpackage

// File: rtl/pio_leds_arbiter_if.sv
// Requester handshake plus Avalon-MM PIO bus seen by the LED arbiter.
// master: the arbiter side; slave: the requesters and the PIO slave port.
interface pio_leds_arbiter_if
  import pio_leds_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 10
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;

  logic [1:0]                avm_address;
  logic                      avm_chipselect;
  logic                      avm_write_n;
  logic [PIO_DATA_W_MAX-1:0] avm_writedata;
  logic [PIO_DATA_W_MAX-1:0] avm_readdata;

  modport master (
    input  req, req_data, avm_readdata,
    output ack, avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

  modport slave (
    output req, req_data, avm_readdata,
    input  ack, avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

endinterface

// File: rtl/pio_leds_arbiter_rr_picker.sv
// Combinational round-robin selector: first asserted request at or after ptr.
// Reusable by any PIO arbiter in the platform.
module rr_picker #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Walk backwards from the furthest slot so the nearest hit to ptr wins last
  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % N;
      if (req[cand]) begin
        idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pio_leds_arbiter.sv
// Round-robin write arbiter sharing the LED PIO data register between
// NUM_REQ requesters. Each granted image becomes one zero-wait Avalon write.
// Optional feature: define PIO_LEDS_ARBITER_READBACK_EN to add a READ cycle
// that verifies the written image and sets the sticky err flag on mismatch.
module pio_leds_arbiter
  import pio_leds_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = 10,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  pio_leds_arbiter_if.master bus,
  output logic              busy,
  output logic [IDX_W-1:0]  owner,
  output logic              err
);

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [DATA_W-1:0]  img;
  logic [NUM_REQ-1:0] ack_q;
  logic               cs_q;
  logic               wn_q;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [DATA_W-1:0]  pick_img;
  logic [IDX_W-1:0]   ptr_next;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_img = bus.req_data[pick_idx*DATA_W +: DATA_W];
  assign ptr_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  assign bus.ack            = ack_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write_n    = wn_q;
  assign bus.avm_address    = PIO_LEDS_DATA_ADDR;
  assign bus.avm_writedata  = (state == WRITE) ?
                              {{(PIO_DATA_W_MAX - DATA_W){1'b0}}, img} : '0;

`ifdef PIO_LEDS_ARBITER_READBACK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Arbitration FSM with registered bus strobes, ack pulse and status
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      img   <= '0;
      owner <= '0;
      ack_q <= '0;
      cs_q  <= 1'b0;
      wn_q  <= 1'b1;
      busy  <= 1'b0;
`ifdef PIO_LEDS_ARBITER_READBACK_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack_q <= '0;
          if (pick_valid) begin
            owner <= pick_idx;
            img   <= pick_img;
            cs_q  <= 1'b1;
            wn_q  <= 1'b0;
            busy  <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          wn_q <= 1'b1;
`ifdef PIO_LEDS_ARBITER_READBACK_EN
          state <= READ;
`else
          cs_q  <= 1'b0;
          ack_q <= NUM_REQ'(1) << owner;
          state <= ACK;
`endif
        end
`ifdef PIO_LEDS_ARBITER_READBACK_EN
        READ: begin
          cs_q  <= 1'b0;
          ack_q <= NUM_REQ'(1) << owner;
          if (bus.avm_readdata[DATA_W-1:0] != img) begin
            err_q <= 1'b1;
          end
          state <= ACK;
        end
`endif
        ACK: begin
          ack_q <= '0;
          ptr   <= ptr_next;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_q <= '0;
          cs_q  <= 1'b0;
          wn_q  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_leds_arbiter.sv
// Self-checking bench for pio_leds_arbiter (2 requesters, 10-bit images).
// Follows PIO_LEDS_ARBITER_READBACK_EN so the same file covers both builds.
module tb_pio_leds_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 10;
`ifdef PIO_LEDS_ARBITER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int P = 3 + RB;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  logic owner;
  logic err;

  int compared = 0;
  int mismatched = 0;

  pio_leds_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

  pio_leds_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .owner   (owner),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    req;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          expOwner;
    logic [DW-1:0] expData;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkBus(input string tag, input logic expCs, input logic expWn,
                          input logic [31:0] expWd, input logic [1:0] expAck, input logic expBusy);
    checkOutput({tag, ".cs"},    32'(bus.avm_chipselect), 32'(expCs));
    checkOutput({tag, ".wn"},    32'(bus.avm_write_n),    32'(expWn));
    checkOutput({tag, ".wdata"}, bus.avm_writedata,       expWd);
    checkOutput({tag, ".addr"},  32'(bus.avm_address),    32'd0);
    checkOutput({tag, ".ack"},   32'(bus.ack),            32'(expAck));
    checkOutput({tag, ".busy"},  32'(busy),               32'(expBusy));
  endtask

  task automatic setImg(input int i, input logic [DW-1:0] d);
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic setReadback(input logic [DW-1:0] d);
`ifdef PIO_LEDS_ARBITER_READBACK_EN
    bus.avm_readdata = {22'h0, d};
`else
    bus.avm_readdata = 'x;
`endif
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    checkBus("reset", 1'b0, 1'b1, 32'h0, 2'b00, 1'b0);
    checkOutput("reset.owner", 32'(owner), 32'd0);
    checkOutput("reset.err",   32'(err),   32'd0);
    reset_n = 1'b1;
  endtask

  // One full transaction from an IDLE negedge to the following IDLE negedge
  task automatic applyStimulus(input string tag, input vec_t v, input logic expErr);
    bus.req = v.req;
    setImg(0, v.d0);
    setImg(1, v.d1);
    setReadback(v.expData);
    @(negedge clk);
    checkBus({tag, ".write"}, 1'b1, 1'b0, {22'h0, v.expData}, 2'b00, 1'b1);
    checkOutput({tag, ".owner"}, 32'(owner), 32'(v.expOwner));
`ifdef PIO_LEDS_ARBITER_READBACK_EN
    @(negedge clk);
    checkBus({tag, ".read"}, 1'b1, 1'b1, 32'h0, 2'b00, 1'b1);
`endif
    @(negedge clk);
    checkBus({tag, ".ack"}, 1'b0, 1'b1, 32'h0, 2'b01 << v.expOwner, 1'b1);
    bus.req = '0;
    @(negedge clk);
    checkBus({tag, ".idle"}, 1'b0, 1'b1, 32'h0, 2'b00, 1'b0);
    checkOutput({tag, ".err"}, 32'(err), 32'(expErr));
  endtask

  // Transaction-level reference: grants are scheduled by edge number
  task automatic runRandom(input int n);
    int cyc = 0;
    int wrEdge = -100;
    int ackEdge = -100;
    int freeEdge = 0;
    int mPtr = 0;
    int mWin = 0;
    logic [DW-1:0] mImg = '0;
    logic visOwner = 1'b0;
    logic mErr = 1'b0;
    logic badPending = 1'b0;
    logic expCs, expWn, expBusy;
    logic [31:0] expWd;
    logic [1:0] expAck;
    bit found;
    for (int it = 0; it < n; it++) begin
      if (cyc == wrEdge) visOwner = mWin[0];
      if (cyc == ackEdge && badPending) begin
        mErr = 1'b1;
        badPending = 1'b0;
      end
      expCs   = (cyc == wrEdge) || (RB == 1 && cyc == wrEdge + 1);
      expWn   = (cyc != wrEdge);
      expWd   = (cyc == wrEdge) ? {22'h0, mImg} : 32'h0;
      expAck  = (cyc == ackEdge) ? (2'b01 << mWin) : 2'b00;
      expBusy = (cyc >= wrEdge) && (cyc <= ackEdge);
      checkBus($sformatf("rnd%0d", cyc), expCs, expWn, expWd, expAck, expBusy);
      checkOutput($sformatf("rnd%0d.owner", cyc), 32'(owner), 32'(visOwner));
      checkOutput($sformatf("rnd%0d.err", cyc),   32'(err),   32'(mErr));

      for (int i = 0; i < NREQ; i++) begin
        if (cyc == ackEdge && i == mWin) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
          else setImg(i, DW'($urandom));
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) bus.req[i] = 1'b1;
          setImg(i, DW'($urandom));
        end else if (i == mWin && cyc >= wrEdge && cyc < ackEdge && $urandom_range(0, 1) == 1) begin
          setImg(i, DW'($urandom));
        end
      end

      if (RB == 1 && cyc == wrEdge + 1) begin
        if ($urandom_range(0, 7) == 0) begin
          bus.avm_readdata = {22'($urandom), ~mImg};
          badPending = 1'b1;
        end else begin
          bus.avm_readdata = {22'($urandom), mImg};
        end
      end else begin
        bus.avm_readdata = $urandom;
      end

      if (cyc + 1 >= freeEdge && bus.req != '0) begin
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
          int c = (mPtr + j) % NREQ;
          if (!found && bus.req[c]) begin
            found = 1'b1;
            mWin = c;
          end
        end
        mImg     = bus.req_data[mWin*DW +: DW];
        wrEdge   = cyc + 1;
        ackEdge  = wrEdge + 1 + RB;
        freeEdge = wrEdge + 3 + RB;
        mPtr     = (mWin + 1) % NREQ;
      end

      @(negedge clk);
      cyc++;
    end
    bus.req = '0;
  endtask

  initial begin
    int ackCount;
    int wrCount;
    vec_t v;

    bus.req = '0;
    bus.req_data = '0;
    bus.avm_readdata = '0;

    vecs[0] = '{2'b01, 10'h155, 10'h0AA, 1'b0, 10'h155};
    vecs[1] = '{2'b11, 10'h0AA, 10'h3C3, 1'b1, 10'h3C3};
    vecs[2] = '{2'b11, 10'h0AA, 10'h3C3, 1'b0, 10'h0AA};
    vecs[3] = '{2'b01, 10'h2FF, 10'h000, 1'b0, 10'h2FF};
    vecs[4] = '{2'b10, 10'h000, 10'h001, 1'b1, 10'h001};
    vecs[5] = '{2'b10, 10'h3FF, 10'h3FF, 1'b1, 10'h3FF};
    vecs[6] = '{2'b11, 10'h000, 10'h123, 1'b0, 10'h000};

    doReset();
    for (int k = 0; k < 7; k++) begin
      applyStimulus($sformatf("vec%0d", k), vecs[k], 1'b0);
    end

    // Both requesters held: writes alternate, requester 0 first after reset
    doReset();
    bus.req = 2'b11;
    setImg(0, 10'h0AA);
    setImg(1, 10'h3C3);
    for (int t = 1; t <= 4 * P; t++) begin
      int ph = (t - 1) % P;
      int k  = (t - 1) / P;
      logic [DW-1:0] expd = (k % 2 == 1) ? 10'h3C3 : 10'h0AA;
      @(negedge clk);
      if (ph == 0) begin
        checkBus($sformatf("alt%0d.write", k), 1'b1, 1'b0, {22'h0, expd}, 2'b00, 1'b1);
        checkOutput($sformatf("alt%0d.owner", k), 32'(owner), 32'(k % 2));
        setReadback(expd);
      end
      if (ph == P - 2) begin
        checkOutput($sformatf("alt%0d.ack", k), 32'(bus.ack), 32'(2'b01 << (k % 2)));
      end
      if (ph == P - 1) begin
        checkOutput($sformatf("alt%0d.busy", k), 32'(busy), 32'd0);
      end
    end
    bus.req = '0;

    // Requester 1 pulses req for a single cycle
    bus.req = 2'b10;
    setImg(1, 10'h155);
    setReadback(10'h155);
    @(negedge clk);
    bus.req = '0;
    checkBus("pulse.write", 1'b1, 1'b0, 32'h155, 2'b00, 1'b1);
    checkOutput("pulse.owner", 32'(owner), 32'd1);
    ackCount = 0;
    wrCount = 0;
    for (int t = 0; t < 2 * P; t++) begin
      @(negedge clk);
      if (bus.ack == 2'b10) ackCount++;
      if (bus.ack[0]) ackCount += 100;
      if (bus.avm_chipselect && !bus.avm_write_n) wrCount++;
    end
    checkOutput("pulse.ackcount", 32'(ackCount), 32'd1);
    checkOutput("pulse.extrawrites", 32'(wrCount), 32'd0);

    // Reset during WRITE abandons the transfer; requester 0 wins afterwards
    v = '{2'b01, 10'h111, 10'h000, 1'b0, 10'h111};
    applyStimulus("prerst", v, 1'b0);
    bus.req = 2'b10;
    setImg(1, 10'h222);
    @(negedge clk);
    checkBus("midrst.write", 1'b1, 1'b0, 32'h222, 2'b00, 1'b1);
    reset_n = 1'b0;
    bus.req = 2'b11;
    setImg(0, 10'h0F0);
    setReadback(10'h0F0);
    @(negedge clk);
    checkBus("midrst.reset", 1'b0, 1'b1, 32'h0, 2'b00, 1'b0);
    checkOutput("midrst.owner", 32'(owner), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkBus("postrst.write", 1'b1, 1'b0, 32'h0F0, 2'b00, 1'b1);
    checkOutput("postrst.owner", 32'(owner), 32'd0);
`ifdef PIO_LEDS_ARBITER_READBACK_EN
    @(negedge clk);
`endif
    @(negedge clk);
    checkOutput("postrst.ack", 32'(bus.ack), 32'(2'b01));
    bus.req = '0;
    @(negedge clk);

`ifdef PIO_LEDS_ARBITER_READBACK_EN
    // Slave returns the wrong value: err sets, ack still pulses, err sticks
    bus.req = 2'b01;
    setImg(0, 10'h2FF);
    bus.avm_readdata = 32'h0;
    @(negedge clk);
    checkBus("rbbad.write", 1'b1, 1'b0, 32'h2FF, 2'b00, 1'b1);
    @(negedge clk);
    checkBus("rbbad.read", 1'b1, 1'b1, 32'h0, 2'b00, 1'b1);
    checkOutput("rbbad.errpre", 32'(err), 32'd0);
    @(negedge clk);
    checkOutput("rbbad.ack", 32'(bus.ack), 32'(2'b01));
    checkOutput("rbbad.err", 32'(err), 32'd1);
    bus.req = '0;
    @(negedge clk);
    v = '{2'b11, 10'h155, 10'h2AA, 1'b1, 10'h2AA};
    applyStimulus("rbsticky", v, 1'b1);
    doReset();
`else
    // Readdata left undriven must not disturb err or timing
    setReadback('0);
    v = '{2'b01, 10'h2FF, 10'h000, 1'b1, 10'h2FF};
    v.expOwner = 1'b0;
    applyStimulus("noreadback", v, 1'b0);
    doReset();
`endif

    runRandom(600);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
